// File: rtl/quad_steer_decoder_pkg.sv
// Shared types and Gray-step decoding for the steering quadrature decoder.
package quad_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_e;

  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q10 = 2'b10;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q01 = 2'b01;

  // Position of a {A,B} code along the forward cycle 00->10->11->01.
  function automatic logic [1:0] gray_idx(input logic [1:0] q);
    case (q)
      Q00:     gray_idx = 2'd0;
      Q10:     gray_idx = 2'd1;
      Q11:     gray_idx = 2'd2;
      default: gray_idx = 2'd3;
    endcase
  endfunction

  // Returns {valid, dir, illegal} for a prev -> cur transition.
  function automatic logic [2:0] step_of(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] delta;
    delta = gray_idx(cur) - gray_idx(prev);
    case (delta)
      2'd1:    step_of = 3'b110;
      2'd3:    step_of = 3'b100;
      2'd2:    step_of = 3'b001;
      default: step_of = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// Two-flop synchroniser plus hold-time filter for one raw quadrature line.
module quad_glitch_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic CLK,
  input  logic Reset_n,
  input  logic d,
  output logic q,
  output logic stable,
  output logic sync
);

  localparam logic [3:0] LAST = 4'(FILTER_LEN - 1);

  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       filt_q, filt_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] run_q, run_d;
  logic [1:0] warm_q, warm_d;

  always_comb begin
    s1_d   = d;
    s2_d   = s1_q;
    filt_d = filt_q;
    cnt_d  = 4'd0;
    if (s2_q != filt_q) begin
      if (cnt_q == LAST) filt_d = s2_q;
      else               cnt_d  = cnt_q + 4'd1;
    end
    // warm_q tracks when s2 first carries a sampled value rather than its reset value;
    // run_q counts consecutive samples of the current s2 value, saturating at LAST.
    warm_d = {warm_q[0], 1'b1};
    run_d  = run_q;
    if (!warm_q[1] || (s1_q != s2_q)) run_d = 4'd0;
    else if (run_q != LAST)           run_d = run_q + 4'd1;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
      cnt_q  <= 4'd0;
      run_q  <= 4'd0;
      warm_q <= 2'b00;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      warm_q <= warm_d;
    end
  end

  // stable is high on the edge where the filter holds (or accepts) s2, so sync is its next q.
  assign q      = filt_q;
  assign stable = warm_q[1] && (run_q == LAST);
  assign sync   = s2_q;

endmodule

// File: rtl/quad_steer_decoder.sv
// Quadrature (A,B) to signed wheel position decoder with illegal-transition counting.
module quad_steer_decoder
  import quad_pkg::*;
#(
  parameter int FILTER_LEN = 3,
  parameter int CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             clear,
  input  logic             steer_a,
  input  logic             steer_b,
  output logic [CNT_W-1:0] position,
  output logic             step_valid,
  output logic             step_dir,
  output logic             illegal,
  output logic [7:0]       err_count,
  output logic             locked
);

  logic filt_a, filt_b, stable_a, stable_b, sync_a, sync_b;

  quad_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .CLK(CLK), .Reset_n(Reset_n), .d(steer_a), .q(filt_a), .stable(stable_a), .sync(sync_a)
  );

  quad_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .CLK(CLK), .Reset_n(Reset_n), .d(steer_b), .q(filt_b), .stable(stable_b), .sync(sync_b)
  );

  state_e           state_q, state_d;
  logic             locked_q, locked_d;
  logic [1:0]       prev_q, prev_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [7:0]       err_q, err_d;
  logic             valid_q, valid_d;
  logic             dir_q, dir_d;
  logic             ill_q, ill_d;
  logic [1:0]       cur;
  logic [2:0]       step;

  assign cur = {filt_a, filt_b};

  always_comb begin
    state_d  = state_q;
    locked_d = locked_q;
    prev_d   = prev_q;
    pos_d    = pos_q;
    err_d    = err_q;
    valid_d  = 1'b0;
    dir_d    = 1'b0;
    ill_d    = 1'b0;
    step     = 3'b000;
    case (state_q)
      INIT: begin
        if (stable_a && stable_b) begin
          state_d  = TRACK;
          locked_d = 1'b1;
          prev_d   = {sync_a, sync_b};
        end
      end
      TRACK: begin
        step                   = step_of(prev_q, cur);
        {valid_d, dir_d, ill_d} = step;
        prev_d                 = cur;
        if (valid_d) pos_d = dir_d ? pos_q + CNT_W'(1) : pos_q - CNT_W'(1);
        if (ill_d && (err_q != 8'hFF)) err_d = err_q + 8'd1;
      end
    endcase
    // clear wins over a same-cycle step or illegal event; the pulses still fire.
    if (clear) begin
      pos_d = '0;
      err_d = 8'd0;
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= INIT;
      locked_q <= 1'b0;
      prev_q   <= Q00;
      pos_q    <= '0;
      err_q    <= 8'd0;
      valid_q  <= 1'b0;
      dir_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      locked_q <= locked_d;
      prev_q   <= prev_d;
      pos_q    <= pos_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      dir_q    <= dir_d;
      ill_q    <= ill_d;
    end
  end

  assign position   = pos_q;
  assign step_valid = valid_q;
  assign step_dir   = dir_q;
  assign illegal    = ill_q;
  assign err_count  = err_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_quad_steer_decoder.sv
// Directed bench for quad_steer_decoder: driver tasks push expected pulses, a monitor pops them.
module tb_quad_steer_decoder;

  localparam int FL = 3;
  localparam int W  = 50;  // {due[31:0], illegal, dir, position[7:0], err_count[7:0]}

  logic       CLK = 1'b0;
  logic       Reset_n = 1'b1;
  logic       clear = 1'b0;
  logic       steer_a = 1'b1;
  logic       steer_b = 1'b1;
  logic [7:0] position;
  logic       step_valid, step_dir, illegal, locked;
  logic [7:0] err_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic [1:0]   model_ab;
  logic [7:0]   model_pos;
  logic [7:0]   model_err;

  quad_steer_decoder #(.FILTER_LEN(FL), .CNT_W(8)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .clear(clear), .steer_a(steer_a), .steer_b(steer_b),
    .position(position), .step_valid(step_valid), .step_dir(step_dir), .illegal(illegal),
    .err_count(err_count), .locked(locked)
  );

  // clock / cycle counter
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // 0 none, 1 forward, 2 reverse, 3 illegal
  function automatic logic [1:0] classify(input logic [1:0] p, input logic [1:0] c);
    case ({p, c})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: return 2'd1;
      4'b0001, 4'b0111, 4'b1110, 4'b1000: return 2'd2;
      4'b0011, 4'b1100, 4'b1001, 4'b0110: return 2'd3;
      default:                            return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] fwd(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Drive a new {A,B}; the decoded pulse is due 3+FL edges after the change.
  task automatic set_ab(input logic [1:0] ab, input int hold, input bit clr_at_due);
    logic [1:0] k;
    k = classify(model_ab, ab);
    if (k == 2'd1) model_pos = model_pos + 8'd1;
    else if (k == 2'd2) model_pos = model_pos - 8'd1;
    else if (k == 2'd3 && model_err != 8'hFF) model_err = model_err + 8'd1;
    if (clr_at_due) begin
      model_pos = 8'd0;
      model_err = 8'd0;
    end
    if (k != 2'd0) exp_q.push_back({32'(cyc + 3 + FL), (k == 2'd3), (k == 2'd1), model_pos, model_err});
    model_ab = ab;
    steer_a  = ab[1];
    steer_b  = ab[0];
    if (clr_at_due) begin
      tick(FL + 2);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      tick(hold - FL - 3);
    end else begin
      tick(hold);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    model_pos = 8'd0;
    model_err = 8'd0;
  endtask

  // scoreboard monitor
  always @(negedge CLK) begin
    if (Reset_n) begin
      if (exp_q.size() != 0 && int'(exp_q[0][49:18]) == cyc) begin
        mon_e = exp_q.pop_front();
        chk("step_valid", {31'd0, step_valid}, {31'd0, ~mon_e[17]});
        chk("illegal", {31'd0, illegal}, {31'd0, mon_e[17]});
        chk("step_dir", {31'd0, step_dir}, {31'd0, mon_e[16]});
        chk("position", {24'd0, position}, {24'd0, mon_e[15:8]});
        chk("err_count", {24'd0, err_count}, {24'd0, mon_e[7:0]});
      end else begin
        chk("quiet", {30'd0, step_valid, illegal}, 32'd0);
      end
    end
  end

  initial begin
    model_ab  = 2'b11;
    model_pos = 8'd0;
    model_err = 8'd0;
    #1 Reset_n = 1'b0;
    tick(2);
    chk("rst_position", {24'd0, position}, 32'd0);
    chk("rst_outputs", {28'd0, step_valid, step_dir, illegal, locked}, 32'd0);
    chk("rst_err", {24'd0, err_count}, 32'd0);

    // lock onto 11: edge 0 is the first edge after release
    Reset_n = 1'b1;
    tick(4);
    chk("locked_edge3", {31'd0, locked}, 32'd0);
    tick(1);
    chk("locked_edge4", {31'd0, locked}, 32'd1);
    tick(5);
    chk("lock_position", {24'd0, position}, 32'd0);

    // back to 00 (+2), then clear
    set_ab(2'b01, 8, 1'b0);
    set_ab(2'b00, 8, 1'b0);
    chk("pos_after_two", {24'd0, position}, 32'd2);
    pulse_clear();
    chk("pos_cleared", {24'd0, position}, 32'd0);

    // full forward cycle
    set_ab(2'b10, 8, 1'b0);
    set_ab(2'b11, 8, 1'b0);
    set_ab(2'b01, 8, 1'b0);
    set_ab(2'b00, 8, 1'b0);
    chk("fwd_cycle_pos", {24'd0, position}, 32'd4);

    // 2-cycle glitch on A is rejected
    steer_a = 1'b1;
    tick(2);
    steer_a = 1'b0;
    tick(8);
    chk("glitch2_pos", {24'd0, position}, 32'd4);

    // 3-cycle pulse is accepted: +1 then -1
    set_ab(2'b10, 3, 1'b0);
    set_ab(2'b00, 8, 1'b0);
    chk("pulse3_pos", {24'd0, position}, 32'd4);

    // double-bit transitions
    set_ab(2'b11, 8, 1'b0);
    chk("illegal_err1", {24'd0, err_count}, 32'd1);
    chk("illegal_pos", {24'd0, position}, 32'd4);
    for (int i = 0; i < 299; i++) set_ab(model_ab ^ 2'b11, 6, 1'b0);
    chk("err_saturate", {24'd0, err_count}, 32'd255);
    pulse_clear();
    chk("err_cleared", {24'd0, err_count}, 32'd0);

    // wrap upward
    for (int i = 0; i < 127; i++) set_ab(fwd(model_ab), 6, 1'b0);
    chk("pos_7f", {24'd0, position}, 32'h7F);
    set_ab(fwd(model_ab), 6, 1'b0);
    chk("pos_80", {24'd0, position}, 32'h80);

    // wrap downward
    pulse_clear();
    set_ab(rev(model_ab), 6, 1'b0);
    chk("pos_ff", {24'd0, position}, 32'hFF);

    // clear coincident with a step pulse
    set_ab(model_ab ^ 2'b11, 8, 1'b0);
    chk("pre_clear_err", {24'd0, err_count}, 32'd1);
    set_ab(fwd(model_ab), 10, 1'b1);
    chk("clr_step_pos", {24'd0, position}, 32'd0);
    chk("clr_step_err", {24'd0, err_count}, 32'd0);

    // reset in the middle of a filtered change
    set_ab(fwd(model_ab), 8, 1'b0);
    set_ab(model_ab ^ 2'b11, 8, 1'b0);
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("pre_reset_pos", {24'd0, position}, 32'd1);
    steer_a = ~steer_a;
    tick(2);
    Reset_n = 1'b0;
    #1;
    chk("midrst_position", {24'd0, position}, 32'd0);
    chk("midrst_err", {24'd0, err_count}, 32'd0);
    chk("midrst_outputs", {28'd0, step_valid, step_dir, illegal, locked}, 32'd0);
    tick(2);
    model_ab  = {steer_a, steer_b};
    model_pos = 8'd0;
    model_err = 8'd0;
    Reset_n = 1'b1;
    tick(10);
    chk("relock", {31'd0, locked}, 32'd1);
    chk("relock_pos", {24'd0, position}, 32'd0);

    set_ab(fwd(model_ab), 8, 1'b0);
    chk("post_relock_pos", {24'd0, position}, 32'd1);
    chk("final_queue", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quad_steer_decoder.md
Name: quad_steer_decoder

Overview:
- Receiving end of the steering quadrature interface: turns a 2-bit quadrature pair (A, B), as produced by the joystick-to-quadrature encoder, back into a signed wheel position.
- Used by the harness as a loopback checker for the encoder.
- Also serves as a decoder for external spinner/wheel controllers on USER_IN.
- Synchronises and de-glitches the raw lines, decodes Gray steps, counts position, and flags illegal transitions.

Parameters:
- FILTER_LEN, 3: cycles a synchronised input must hold a new value before it is accepted (range 1–15).
- CNT_W, 8: position counter width, two's complement.

Ports:
- CLK  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous; zeroes position and err_count
- steer_a  in  1  raw quadrature A, asynchronous
- steer_b  in  1  raw quadrature B, asynchronous
- position  out  CNT_W  signed accumulated steps, wraps
- step_valid  out  1  one-cycle pulse per accepted step
- step_dir  out  1  1 = increment (A leads B), 0 = decrement; valid with step_valid
- illegal  out  1  one-cycle pulse on a double-bit transition
- err_count  out  8  count of illegal events, saturating at 255
- locked  out  1  1 once the initial state has been captured

Behaviour:
- Reset values (async assert, sync deassert irrelevant): every output is 0; sync flops, filter state and prev_state are 00; FSM is INIT.
- Synchroniser: two flops per line. The synchronised value s2 is available after 2 edges.
- Filter, per bit, with counter cnt:
  - if s2 != filt: when cnt == FILTER_LEN-1, filt <= s2 and cnt <= 0; otherwise cnt++.
  - if s2 == filt: cnt <= 0.
  - Pulses shorter than FILTER_LEN cycles are never accepted.
  - With FILTER_LEN = 1, filt follows s2 with one cycle of delay.
- FSM states: INIT, TRACK.
  - INIT: waits until both bits have been stable for FILTER_LEN cycles since reset. Then loads filt and prev_state with the current value, sets locked = 1 and moves to TRACK. No step or illegal output during INIT.
  - TRACK: each cycle compares cur = {A_f, B_f} against prev_state, then prev_state <= cur.
- Decoding in TRACK:
  - Forward sequence ({A,B}): 00→10→11→01→00. A forward step does position +1, step_dir = 1.
  - Reverse sequence: 00→01→11→10→00. A reverse step does position -1, step_dir = 0.
  - cur == prev_state: no action.
  - Both bits changed (00↔11, 10↔01): illegal = 1, err_count++ (holds at 255), position unchanged, step_valid = 0.
  - Decode results are registered: step_valid, step_dir, illegal and position update on the edge after filt changes.
- Latency: with a raw change stable before edge 0, filt updates at edge 1+FILTER_LEN and step_valid/position at edge 2+FILTER_LEN.
- Throughput: at most one step per FILTER_LEN+1 cycles by construction. An edge arriving while the previous one is still being filtered restarts cnt.
- Wrap: position is modulo 2^CNT_W. 0x7F+1 → 0x80 and 0x00-1 → 0xFF for CNT_W = 8.
- clear:
  - Has priority over a simultaneous step or illegal event: position and err_count go to 0.
  - step_valid/illegal pulses still fire that cycle.
  - prev_state still updates.
  - FSM state is unaffected.
- Reset asserted mid-operation: immediate return to reset values, including INIT with locked = 0.

Decomposition:
- Package quad_pkg holds:
  - state enum {INIT, TRACK};
  - 2-bit localparams Q00, Q10, Q11, Q01;
  - a function step_of(prev, cur) returning {valid, dir, illegal}.
- One sub-module, quad_glitch_filter (params FILTER_LEN; ports CLK, Reset_n, d, q, stable). It contains the 2-flop synchroniser and filter counter and is instantiated once per line. `stable` feeds the INIT exit condition.

Test Plan:
- Reset, hold A=1,B=1 for 10 cycles, FILTER_LEN=3 → locked=1 at edge 4, no step_valid, no illegal, position=0.
- Forward cycle 00→10→11→01→00, each held 8 cycles → 4 step_valid pulses with step_dir=1, position=4. Each pulse appears at edge 5 after its raw change.
- 2-cycle glitch on A from 00, FILTER_LEN=3 → no step_valid, position unchanged. Repeat with a 3-cycle pulse → one +1 step then one -1 step, net 0.
- Force 00→11 (both bits simultaneously) → single illegal pulse, err_count=1, position unchanged. Repeat 300 times → err_count=255.
- From position=0x7F, one forward step → 0x80. From 0x00, one reverse step → 0xFF.
- Assert clear in the same cycle as step_valid → position=0 and err_count=0 next cycle. Drop Reset_n mid-sequence → all outputs 0 and locked=0 immediately.
